// File: rtl/booth_mult_sched.sv
// Round-robin scheduler in front of one sequential radix-2 Booth multiplier.
// One job at a time: accept in IDLE, WIDTH Booth steps in ITER, hold the product in DONE.
module booth_mult_sched #(
  parameter int WIDTH = 9,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [IDW-1:0]          resp_id,
  output logic [2*WIDTH-1:0]      resp_product,
  output logic                    busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH:0]   acc_reg;
  logic [WIDTH:0]   m_reg;
  logic [WIDTH-1:0] q_reg;
  logic             qm1_reg;
  logic [CW-1:0]    cnt_reg;
  logic [IDW-1:0]   id_reg;
  logic [IDW-1:0]   last_grant_reg;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin search starting just after the last granted requester.
  logic [NREQ-1:0] grant_next;
  logic [IDW-1:0]  grant_id_next;
  logic            grant_any_next;
  logic [IDW-1:0]  sel;

  always_comb begin
    grant_next     = '0;
    grant_id_next  = '0;
    grant_any_next = 1'b0;
    sel            = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sel = IDW'((int'(last_grant_reg) + k) % NREQ);
      if (!grant_any_next && req_valid[sel]) begin
        grant_next[sel] = 1'b1;
        grant_id_next   = sel;
        grant_any_next  = 1'b1;
      end
    end
  end

  assign req_ready = (state_reg == IDLE && !rst) ? grant_next : '0;
  assign busy      = (state_reg != IDLE);

  // One Booth step: conditional add/subtract, then arithmetic shift of {acc,Q,q_m1}.
  logic [WIDTH:0]   sum_next;
  logic [WIDTH:0]   acc_sh_next;
  logic [WIDTH-1:0] q_sh_next;

  always_comb begin
    case ({q_reg[0], qm1_reg})
      2'b01:   sum_next = acc_reg + m_reg;
      2'b10:   sum_next = acc_reg - m_reg;
      default: sum_next = acc_reg;
    endcase
    acc_sh_next = {sum_next[WIDTH], sum_next[WIDTH:1]};
    q_sh_next   = {sum_next[0], q_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      acc_reg        <= '0;
      m_reg          <= '0;
      q_reg          <= '0;
      qm1_reg        <= 1'b0;
      cnt_reg        <= '0;
      id_reg         <= '0;
      last_grant_reg <= IDW'(NREQ - 1);
      resp_valid     <= 1'b0;
      resp_id        <= '0;
      resp_product   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any_next) begin
            acc_reg        <= '0;
            q_reg          <= a_arr[grant_id_next];
            qm1_reg        <= 1'b0;
            m_reg          <= {b_arr[grant_id_next][WIDTH-1], b_arr[grant_id_next]};
            cnt_reg        <= '0;
            id_reg         <= grant_id_next;
            last_grant_reg <= grant_id_next;
            state_reg      <= ITER;
          end
        end
        ITER: begin
          acc_reg <= acc_sh_next;
          q_reg   <= q_sh_next;
          qm1_reg <= q_reg[0];
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(WIDTH - 1)) begin
            resp_product <= {acc_sh_next[WIDTH-1:0], q_sh_next};
            resp_id      <= id_reg;
            resp_valid   <= 1'b1;
            state_reg    <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_sched.sv
// Scenario bench for booth_mult_sched: expected products are pushed on accept and
// popped when the response appears.
`timescale 1ns/1ps
module tb_booth_mult_sched;
  localparam int WIDTH = 9;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int PW    = 2 * WIDTH;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic                  resp_valid;
  logic                  resp_ready = 1'b1;
  logic [IDW-1:0]        resp_id;
  logic [PW-1:0]         resp_product;
  logic                  busy;

  booth_mult_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_product(resp_product), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [IDW-1:0] id; logic [PW-1:0] p; } exp_t;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  function automatic logic [PW-1:0] model(input int a, input int b);
    int p;
    p = a * b;
    return p[PW-1:0];
  endfunction

  task automatic set_ops(input int i, input int a, input int b);
    logic [WIDTH-1:0] ta, tb;
    ta = a[WIDTH-1:0];
    tb = b[WIDTH-1:0];
    req_a[i*WIDTH +: WIDTH] = ta;
    req_b[i*WIDTH +: WIDTH] = tb;
  endtask

  task automatic do_reset();
    req_valid = '0;
    resp_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input int i, input int a, input int b, output int acc_cyc, output bit ok);
    exp_t e;
    set_ops(i, a, b);
    req_valid[i] = 1'b1;
    ok = 1'b0;
    acc_cyc = 0;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (req_ready[i]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL accept_timeout req=%0d got req_ready=%b want bit %0d set", i, req_ready, i);
      req_valid[i] = 1'b0;
    end else begin
      e.id = IDW'(i);
      e.p  = model(a, b);
      sb.push_back(e);
      @(negedge clk);
      acc_cyc = cyc;
      req_valid[i] = 1'b0;
      set_ops(i, 170, -85);
    end
  endtask

  task automatic wait_resp(output bit seen, output int at);
    seen = 1'b0;
    at = 0;
    for (int n = 0; n < 60; n++) begin
      if (resp_valid) begin
        seen = 1'b1;
        at = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({resp_valid, busy, resp_id, resp_product, req_ready} !== '0) begin
      fails++;
      $display("FAIL reset_values got v=%b busy=%b id=%0d p=%h rdy=%b want all 0",
               resp_valid, busy, resp_id, resp_product, req_ready);
    end
    rst = 1'b0;
    req_valid = 4'b1111;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL reset_priority got %b want 0001", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int acc_cyc, at, busy_low;
    bit ok, seen;
    exp_t e;
    do_reset();
    set_ops(0, 3, 5);
    req_valid = 4'b0001;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL basic_ready got %b want 0001", req_ready);
    end
    issue(0, 3, 5, acc_cyc, ok);
    busy_low = 0;
    for (int n = 0; n < 60 && !resp_valid; n++) begin
      if (busy !== 1'b1) busy_low++;
      @(negedge clk);
    end
    wait_resp(seen, at);
    if (busy !== 1'b1) busy_low++;
    tests++;
    if (busy_low != 0) begin
      fails++;
      $display("FAIL basic_busy got %0d low cycles want 0", busy_low);
    end
    tests++;
    if (!seen || at - acc_cyc != WIDTH) begin
      fails++;
      $display("FAIL basic_latency got seen=%0b lat=%0d want %0d", seen, at - acc_cyc, WIDTH);
    end
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (resp_id !== e.id || resp_product !== e.p || resp_product !== 18'd15) begin
        fails++;
        $display("FAIL basic_product got id=%0d p=%h want id=%0d p=%h", resp_id, resp_product, e.id, e.p);
      end
    end
    @(negedge clk);
    tests++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle got v=%b busy=%b want 0 0", resp_valid, busy);
    end
  endtask

  task automatic test_signed();
    int ids[3]  = '{2, 1, 1};
    int as[3]   = '{-7, -256, 255};
    int bs[3]   = '{6, -256, -256};
    logic [PW-1:0] want[3] = '{18'h3FFD6, 18'h10000, 18'h30100};
    int acc_cyc, at;
    bit ok, seen;
    exp_t e;
    for (int j = 0; j < 3; j++) begin
      issue(ids[j], as[j], bs[j], acc_cyc, ok);
      wait_resp(seen, at);
      tests++;
      if (!seen || sb.size() == 0) begin
        fails++;
        $display("FAIL signed_resp_%0d got seen=%0b want response", j, seen);
      end else begin
        e = sb.pop_front();
        tests++;
        if (resp_id !== e.id || resp_product !== e.p || resp_product !== want[j]) begin
          fails++;
          $display("FAIL signed_product_%0d got id=%0d p=%h want id=%0d p=%h",
                   j, resp_id, resp_product, e.id, want[j]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    int ra[4] = '{17, -100, -256, 200};
    int rb[4] = '{-3, 77, -256, 255};
    int order[5] = '{0, 1, 2, 3, 0};
    int nacc, nresp, prev, g;
    bit drop;
    logic [NREQ-1:0] hit;
    exp_t e;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, ra[i], rb[i]);
    req_valid = 4'b1111;
    nacc = 0; nresp = 0; prev = 0; drop = 1'b0;
    for (int n = 0; n < 200 && (nacc < 5 || nresp < 5); n++) begin
      if (drop) req_valid = '0;
      #1;
      hit = req_ready & req_valid;
      if (hit != '0 && nacc < 5) begin
        g = 0;
        for (int i = 0; i < NREQ; i++) if (hit[i]) g = i;
        tests++;
        if (g != order[nacc]) begin
          fails++;
          $display("FAIL rr_order_%0d got %0d want %0d", nacc, g, order[nacc]);
        end
        if (nacc > 0) begin
          tests++;
          if (cyc + 1 - prev != WIDTH + 2) begin
            fails++;
            $display("FAIL rr_interval_%0d got %0d want %0d", nacc, cyc + 1 - prev, WIDTH + 2);
          end
        end
        prev = cyc + 1;
        e.id = IDW'(g);
        e.p  = model(ra[g], rb[g]);
        sb.push_back(e);
        nacc++;
        if (nacc == 5) drop = 1'b1;
      end
      if (resp_valid) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL rr_unexpected_resp got id=%0d want none", resp_id);
        end else begin
          e = sb.pop_front();
          if (resp_id !== e.id || resp_product !== e.p) begin
            fails++;
            $display("FAIL rr_resp_%0d got id=%0d p=%h want id=%0d p=%h",
                     nresp, resp_id, resp_product, e.id, e.p);
          end
        end
        nresp++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    tests++;
    if (nacc != 5 || nresp != 5) begin
      fails++;
      $display("FAIL rr_count got acc=%0d resp=%0d want 5 5", nacc, nresp);
    end
  endtask

  task automatic test_backpressure();
    int acc_cyc, at, bad;
    bit ok, seen;
    exp_t e;
    resp_ready = 1'b0;
    issue(2, -1, -1, acc_cyc, ok);
    set_ops(0, 4, 4);
    req_valid = 4'b0001;
    wait_resp(seen, at);
    tests++;
    if (!seen || at - acc_cyc != WIDTH || sb.size() == 0) begin
      fails++;
      $display("FAIL bp_resp got seen=%0b lat=%0d want latency %0d", seen, at - acc_cyc, WIDTH);
    end else begin
      e = sb.pop_front();
      bad = 0;
      for (int n = 0; n < 20; n++) begin
        if (resp_valid !== 1'b1 || resp_product !== e.p || resp_product !== 18'd1 ||
            resp_id !== e.id || req_ready !== 4'b0000 || busy !== 1'b1) bad++;
        @(negedge clk);
      end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL bp_hold got %0d unstable cycles (p=%h id=%0d) want 0", bad, resp_product, resp_id);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL bp_release got v=%b busy=%b rdy=%b want 0 0 0001", resp_valid, busy, req_ready);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int acc_cyc, at, spurious;
    bit ok, seen;
    exp_t e;
    do_reset();
    issue(0, 12, 12, acc_cyc, ok);
    repeat (4) @(negedge clk);
    set_ops(3, -5, 11);
    req_valid = 4'b1000;
    rst = 1'b1;
    #1;
    tests++;
    if ({resp_valid, busy, resp_id, resp_product, req_ready} !== '0) begin
      fails++;
      $display("FAIL midreset_async got v=%b busy=%b id=%0d p=%h rdy=%b want all 0",
               resp_valid, busy, resp_id, resp_product, req_ready);
    end
    sb.delete();
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int n = 0; n < 15; n++) begin
      if (resp_valid || busy) spurious++;
      @(negedge clk);
    end
    tests++;
    if (spurious != 0) begin
      fails++;
      $display("FAIL midreset_discard got %0d active cycles want 0", spurious);
    end
    req_valid = 4'b1001;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL midreset_pointer got %b want 0001", req_ready);
    end
    req_valid = 4'b0000;
    @(negedge clk);
    issue(3, -5, 11, acc_cyc, ok);
    wait_resp(seen, at);
    tests++;
    if (!seen || sb.size() == 0) begin
      fails++;
      $display("FAIL midreset_req3 got seen=%0b want response", seen);
    end else begin
      e = sb.pop_front();
      if (resp_id !== e.id || resp_product !== e.p) begin
        fails++;
        $display("FAIL midreset_req3 got id=%0d p=%h want id=%0d p=%h", resp_id, resp_product, e.id, e.p);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_pulse();
    int acc_cyc, at;
    bit ok, seen;
    exp_t e;
    issue(0, 7, -9, acc_cyc, ok);
    @(negedge clk);
    set_ops(1, 9, 9);
    req_valid[1] = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL pulse_ready got %b want 0000", req_ready);
    end
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_resp(seen, at);
    tests++;
    if (!seen || sb.size() == 0) begin
      fails++;
      $display("FAIL pulse_resp got seen=%0b want response", seen);
    end else begin
      e = sb.pop_front();
      if (resp_id !== e.id || resp_product !== e.p) begin
        fails++;
        $display("FAIL pulse_resp got id=%0d p=%h want id=%0d p=%h", resp_id, resp_product, e.id, e.p);
      end
    end
    @(negedge clk);
    req_valid = 4'b1010;
    #1;
    tests++;
    if (busy !== 1'b0 || req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL pulse_pointer got busy=%b rdy=%b want 0 0010", busy, req_ready);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_pulse();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
